// File: rtl/conv_strip_ctrl_pkg.sv
// Shared types and default geometry for the 3x3-window strip sequencer.
package conv_strip_ctrl_pkg;

  localparam int IMG_W_D      = 256;
  localparam int PAD_W_D      = IMG_W_D + 2;
  localparam int STRIP_ROWS_D = 32;
  localparam int PIPE_LAT_D   = 2;
  localparam int AW_D         = 15;

  // Beats in one padded load and windows in one run.
  localparam int LOAD_N_D = PAD_W_D * (STRIP_ROWS_D + 2);
  localparam int RUN_N_D  = IMG_W_D * STRIP_ROWS_D;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_strip_ctrl_if.sv
// Load stream, read-memory write port and window/result strobes of the strip sequencer.
interface conv_strip_ctrl_if
  import conv_strip_ctrl_pkg::*;
#(
  parameter int AW = AW_D
);
  // A load beat transfers in the cycle where in_valid and in_ready are both high;
  // the source may drop in_valid at any time and the sequencer never stalls a held beat.
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          rd;
  logic [7:0]    col;
  logic [4:0]    row;
  logic          wr;

  modport master (
    input  in_valid,
    output in_ready, mem_we, mem_waddr, rd, col, row, wr
  );

  modport slave (
    output in_valid,
    input  in_ready, mem_we, mem_waddr, rd, col, row, wr
  );

endinterface

// File: rtl/conv_strip_ctrl_strip_win_cnt.sv
// Row-major window position counter: col wraps at IMG_W-1 and bumps row; last marks the final window.
module strip_win_cnt #(
  parameter int IMG_W      = 256,
  parameter int STRIP_ROWS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] col,
  output logic [4:0] row,
  output logic       last
);

  localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(STRIP_ROWS - 1);

  assign last = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 5'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/conv_strip_ctrl.sv
// Strip sequencer: load padded pixels, sweep one 3x3 window per cycle, drain the filter pipe.
// Defining CTRL_PAUSE_EN adds a pause input that stalls the window sweep in RUN.
module conv_strip_ctrl
  import conv_strip_ctrl_pkg::*;
#(
  parameter int IMG_W      = IMG_W_D,
  parameter int PAD_W      = PAD_W_D,
  parameter int STRIP_ROWS = STRIP_ROWS_D,
  parameter int PIPE_LAT   = PIPE_LAT_D,
  parameter int AW         = AW_D
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
`ifdef CTRL_PAUSE_EN
  input  logic   pause,
`endif
  output logic   busy,
  output logic   done,
  output logic   mem_clr,
  output state_e state,
  conv_strip_ctrl_if.master bus
);

  localparam int              LOAD_N    = PAD_W * (STRIP_ROWS + 2);
  localparam logic [AW-1:0]   LOAD_LAST = AW'(LOAD_N - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       load_cnt;
  logic [PIPE_LAT-1:0] vld_sr, sr_shift;
  logic                in_ready, rd, accept, stall, win_last, drain_empty;
  logic [7:0]          col;
  logic [4:0]          row;

`ifdef CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign accept = bus.in_valid & in_ready;

  // DRAIN ends once nothing is left to shift toward wr after this cycle.
  assign sr_shift    = vld_sr << 1;
  assign drain_empty = (sr_shift == '0);

  strip_win_cnt #(
    .IMG_W      (IMG_W),
    .STRIP_ROWS (STRIP_ROWS)
  ) u_win (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .en    (rd),
    .col   (col),
    .row   (row),
    .last  (win_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      load_cnt <= '0;
      vld_sr   <= '0;
    end else begin
      state_q <= state_d;
      vld_sr  <= sr_shift | PIPE_LAT'(rd);
      if (state_q == IDLE) begin
        load_cnt <= '0;
      end else if (accept) begin
        load_cnt <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    rd       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mem_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (bus.in_valid && (load_cnt == LOAD_LAST)) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        rd   = ~stall;
        if (!stall && win_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_empty) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        mem_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state         = state_q;
  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = accept;
  assign bus.mem_waddr = load_cnt;
  assign bus.rd        = rd;
  assign bus.col       = col;
  assign bus.row       = row;
  assign bus.wr        = vld_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_conv_strip_ctrl.sv
// Directed bench for conv_strip_ctrl: full strips, gapped load, abort by reset, optional pause.
module tb_conv_strip_ctrl;
  import conv_strip_ctrl_pkg::*;

  localparam int AW     = AW_D;
  localparam int LOAD_N = LOAD_N_D;
  localparam int RUN_N  = RUN_N_D;
  localparam int LAT    = PIPE_LAT_D;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   pause = 1'b0;
  logic   busy, done, mem_clr;
  state_e state;

  conv_strip_ctrl_if #(.AW(AW)) bus ();

  conv_strip_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef CTRL_PAUSE_EN
    .pause   (pause),
`endif
    .busy    (busy),
    .done    (done),
    .mem_clr (mem_clr),
    .state   (state),
    .bus     (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [AW-1:0] exp_addr_q[$];
  logic [12:0]   exp_win_q[$];
  int            exp_wr_q[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt, done_cnt, clr_cnt, load_len, run_len, drain_len;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; clr_cnt = 0;
    load_len = 0; run_len = 0; drain_len = 0;
  endtask

  task automatic push_windows();
    for (int r = 0; r < STRIP_ROWS_D; r++)
      for (int c = 0; c < IMG_W_D; c++)
        exp_win_q.push_back({5'(r), 8'(c)});
  endtask

  // monitor: pops expectations whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid) begin
        check("in_ready", 32'(bus.in_ready), 32'd1);
        check("mem_we", 32'(bus.mem_we), 32'd1);
        if (exp_addr_q.size() == 0) check("mem_waddr_unexpected", 32'(bus.mem_waddr), 32'hffff_ffff);
        else check("mem_waddr", 32'(bus.mem_waddr), 32'(exp_addr_q.pop_front()));
      end else begin
        check("mem_we_no_valid", 32'(bus.mem_we), 32'd0);
      end
      if (bus.rd) begin
        rd_cnt++;
        if (exp_win_q.size() == 0) check("window_unexpected", 32'({bus.row, bus.col}), 32'hffff_ffff);
        else check("window_row_col", 32'({bus.row, bus.col}), 32'(exp_win_q.pop_front()));
        exp_wr_q.push_back(cyc + LAT);
      end
      if (bus.wr) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(cyc), 32'hffff_ffff);
        else check("wr_cycle", 32'(cyc), 32'(exp_wr_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        check("mem_clr_with_done", 32'(mem_clr), 32'd1);
      end
      if (mem_clr) clr_cnt++;
      if (state == LOAD)  load_len++;
      if (state == RUN)   run_len++;
      if (state == DRAIN) drain_len++;
    end
  end

  // driver tasks
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_to_load", 32'(state), 32'(LOAD));
    check("load_busy", 32'(busy), 32'd1);
  endtask

  task automatic load_beats(input bit gaps, input int nbeats);
    int beats = 0;
    int c = 0;
    while (beats < nbeats) begin
      if (gaps && (c % 2 == 1)) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        exp_addr_q.push_back(AW'(beats));
        beats++;
      end
      c++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_strip(input bit gaps, input bit do_pause, input bit start_in_done);
    int n = 0;
    bit paused_done = 1'b0;
    int pause_len = 0;
    clear_stats();
    push_windows();
    do_start();
    load_beats(gaps, LOAD_N);
    #1;
    check("run_first_rd", 32'(bus.rd), 32'd1);
    check("run_first_col", 32'(bus.col), 32'd0);
    check("run_first_row", 32'(bus.row), 32'd0);
    check("run_in_ready", 32'(bus.in_ready), 32'd0);
    while (!done && n < 40000) begin
`ifdef CTRL_PAUSE_EN
      if (do_pause && !paused_done && bus.rd && bus.col == 8'd100 && bus.row == 5'd0) begin
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          check("pause_rd", 32'(bus.rd), 32'd0);
          check("pause_col", 32'(bus.col), 32'd100);
          @(posedge clk); #1;
        end
        pause = 1'b0;
        paused_done = 1'b1;
        pause_len = 5;
        #1;
        check("resume_col", 32'(bus.col), 32'd100);
      end
`endif
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_mem_clr", 32'(mem_clr), 32'd1);
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("after_done_state", 32'(state), 32'(IDLE));
    check("after_done_busy", 32'(busy), 32'd0);
    check("after_done_pulse", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("idle_stays", 32'(state), 32'(IDLE));
    check("rd_count", 32'(rd_cnt), 32'(RUN_N));
    check("wr_count", 32'(wr_cnt), 32'(RUN_N));
    check("done_count", 32'(done_cnt), 32'd1);
    check("mem_clr_count", 32'(clr_cnt), 32'd1);
    check("load_len", 32'(load_len), gaps ? 32'(2 * LOAD_N - 1) : 32'(LOAD_N));
    check("run_len", 32'(run_len), 32'(RUN_N + pause_len));
    check("drain_len", 32'(drain_len), 32'(LAT));
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("win_q_empty", 32'(exp_win_q.size()), 32'd0);
    check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_clr"}, 32'(mem_clr), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_waddr"}, 32'(bus.mem_waddr), 32'd0);
    check({tag, "_rd"}, 32'(bus.rd), 32'd0);
    check({tag, "_wr"}, 32'(bus.wr), 32'd0);
    check({tag, "_col"}, 32'(bus.col), 32'd0);
    check({tag, "_row"}, 32'(bus.row), 32'd0);
  endtask

  task automatic abort_test();
    int n = 0;
    clear_stats();
    push_windows();
    do_start();
    load_beats(1'b0, LOAD_N);
    while (bus.row != 5'd10 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_at_row", 32'(bus.row), 32'd10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst_n = 1'b1;
    exp_win_q.delete();
    exp_wr_q.delete();
    do_start();
    load_beats(1'b0, 16);
    #1;
    check("reload_addr", 32'(bus.mem_waddr), 32'd16);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reload_abort_state", 32'(state), 32'(IDLE));
    check("reload_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
  endtask

  // main sequence
  initial begin
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 32'(state), 32'(IDLE));
    run_strip(1'b0, 1'b1, 1'b0);
    run_strip(1'b1, 1'b0, 1'b1);
    abort_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_strip_ctrl.md
Name: conv_strip_ctrl

Overview:
- Sequencer for the 3x3-window strip buffer: the padded read memory of PAD_W x (STRIP_ROWS+2) pixels plus the result write memory.
- Phases, in order:
  - Load: accepts a padded pixel stream and produces write strobes and addresses for the read memory.
  - Run: issues exactly IMG_W*STRIP_ROWS read strobes, one window per cycle, row-major.
  - Drain: tracks filter pipeline latency and generates the result-write strobe.
- Finishes by pulsing done and mem_clr, so the buffer's internal pointers return to zero before the next strip.

Parameters:
- IMG_W, 256, output pixels per row.
- PAD_W, 258, padded row pitch; must equal IMG_W+2.
- STRIP_ROWS, 32, output rows per strip.
- PIPE_LAT, 2, cycles from rd assertion to filtered pixel valid at the write port; must be at least 1.
- AW, 15, write-address width; must satisfy 2^AW >= PAD_W*(STRIP_ROWS+2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a strip; sampled only in IDLE
- in_valid  in  1  load stream pixel valid
- in_ready  out  1  load stream ready
- mem_we  out  1  read-memory write strobe
- mem_waddr  out  AW  read-memory write address
- rd  out  1  window read strobe to buffer
- col  out  8  current window column, 0..IMG_W-1
- row  out  5  current window row, 0..STRIP_ROWS-1
- wr  out  1  result write strobe
- busy  out  1  high in LOAD, RUN, DRAIN
- done  out  1  one-cycle pulse at strip end
- mem_clr  out  1  one-cycle pulse in DONE; integration ANDs its inverse into the buffer's rst_n
- pause  in  1  run-phase stall (only with CTRL_PAUSE_EN)

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Load counter, col, row and the valid shift register are cleared.
- Reset mid-operation aborts immediately to IDLE; any partial strip is discarded.
- Load constants:
  - LOAD_N = PAD_W*(STRIP_ROWS+2); 8772 at defaults.
  - RUN_N = IMG_W*STRIP_ROWS; 8192 at defaults.
- IDLE:
  - in_ready = 0, rd = 0.
  - start = 1 moves to LOAD on the next cycle.
  - start in any other state is ignored.
- LOAD:
  - in_ready = 1.
  - mem_we = in_valid & in_ready, combinational.
  - mem_waddr = load counter, registered.
  - Counter increments on each accepted beat.
  - The accepted beat with counter = LOAD_N-1 moves to RUN; the counter is then cleared.
  - in_valid gaps insert bubbles, with no address advance.
- RUN:
  - rd = 1 every cycle (unless paused).
  - col/row give the window of the current rd: col increments; at col = IMG_W-1, col wraps to 0 and row increments.
  - The rd with row = STRIP_ROWS-1 and col = IMG_W-1 is the last one; the next state is DRAIN.
  - Exactly RUN_N rd cycles per strip.
- Valid tracking:
  - PIPE_LAT-bit shift register; bit 0 is loaded with rd.
  - wr = MSB, so wr is rd delayed by PIPE_LAT cycles.
  - Total wr count per strip = RUN_N.
- DRAIN:
  - rd = 0.
  - Stays until the shift register is all zero, then goes to DONE.
- DONE:
  - done = 1 and mem_clr = 1 for one cycle; next state IDLE.
  - A start in that same cycle is ignored.
- busy = (state is LOAD, RUN or DRAIN).

Optional Feature:
- Macro: CTRL_PAUSE_EN.
- With the macro defined: pause = 1 in RUN forces rd = 0 and holds col/row; the shift register still shifts, so outstanding wr strobes complete. Pause outside RUN has no effect.
- Without the macro: the pause port is absent and RUN never stalls.

Decomposition:
- Shared package holds:
  - State enum: IDLE, LOAD, RUN, DRAIN, DONE.
  - Default IMG_W, PAD_W, STRIP_ROWS, PIPE_LAT.
  - Derived LOAD_N and RUN_N constants.
- One natural sub-module: strip_win_cnt, the col/row counter with wrap and last flag, reused by the buffer model in the testbench.

Test Plan:
- Reset, then start; in_valid held high for 8772 cycles → mem_waddr 0..8771 with mem_we every cycle; RUN begins the next cycle with col = 0, row = 0.
- Full strip with a reference buffer and a PIPE_LAT=2 filter model → exactly 8192 rd and 8192 wr; first wr 2 cycles after first rd; done and mem_clr pulse once; busy low afterwards.
- Load with in_valid toggling 1,0,1,0 → address advances only on accepted beats; LOAD lasts 17543 cycles.
- Boundary at col = 255, row = 3 → next col = 0, row = 4; last rd at col = 255, row = 31; then DRAIN lasts 2 cycles.
- rst_n low for one cycle mid-RUN (row = 10) → IDLE next cycle, all outputs 0; a new start loads from address 0.
- CTRL_PAUSE_EN: pause for 5 cycles at col = 100 → rd low for 5 cycles, col held at 100, pending wr strobes still emitted; total rd still 8192.
